// File: rtl/surf_cout_multi_parallelizer.sv
// Multi-channel SURF COUT parallelizer: sync-aligned word capture with a freeze handshake,
// training-mode bit-error checking and per-channel lock FSMs. Define COUT_PARALLELIZER_ERRCNT_EN for error counters.
module surf_cout_multi_parallelizer #(
    parameter int NCHAN          = 4,
    parameter int SERDES_WIDTH   = 4,
    parameter int WORD_BEATS     = 8,
    parameter int SYNC_PERIOD    = 16,
    parameter int SYNC_OFFSET    = 4,
    parameter int PATTERN_PERIOD = 8,
    parameter int LOCK_CYCLES    = 64,
    parameter int ERRCNT_WIDTH   = 16
) (
    input  logic                                     sysclk_i,
    input  logic                                     rst_n_i,
    input  logic                                     sync_i,
    input  logic                                     capture_i,
    input  logic                                     captured_i,
    input  logic                                     enable_i,
    input  logic                                     errcnt_clr_i,
    input  logic [NCHAN*SERDES_WIDTH-1:0]            cout_i,
    output logic [NCHAN*SERDES_WIDTH*WORD_BEATS-1:0] cout_parallel_o,
    output logic                                     capture_hold_o,
    output logic [NCHAN-1:0]                         biterr_o,
    output logic [NCHAN-1:0]                         locked_o,
    output logic                                     sync_err_o,
    output logic [NCHAN*ERRCNT_WIDTH-1:0]            errcnt_o
);

    localparam int WORD_W  = SERDES_WIDTH * WORD_BEATS;
    localparam int PAT_W   = SERDES_WIDTH * PATTERN_PERIOD;
    localparam int PHASE_W = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
    localparam int WARM_W  = $clog2(PATTERN_PERIOD + 1);
    localparam int LOCK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SYNC_PERIOD - 1);
    localparam logic [WARM_W-1:0]  WARM_DONE  = WARM_W'(PATTERN_PERIOD);
    localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        UNLOCKED,
        CHECKING,
        LOCKED
    } lock_state_t;

    logic [PHASE_W-1:0] phase;
    logic               sync_seen;
    logic               hold;
    logic               enable_q;
    logic [WARM_W-1:0]  warm_cnt;
    logic               strobe;
    logic               enable_fall;
    logic               warm_done;

    // An off-phase sync is flagged but still realigns the counter.
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase      <= '0;
            sync_seen  <= 1'b0;
            sync_err_o <= 1'b0;
        end else begin
            if (sync_i || phase == PHASE_LAST) begin
                phase <= '0;
            end else begin
                phase <= phase + PHASE_W'(1);
            end
            if (sync_i) begin
                sync_seen <= 1'b1;
            end
            if (sync_i && sync_seen && phase != PHASE_LAST) begin
                sync_err_o <= 1'b1;
            end
        end
    end

    assign strobe = sync_seen &&
                    (((int'(phase) + SYNC_PERIOD - SYNC_OFFSET) % WORD_BEATS) == 0);

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold <= 1'b0;
        end else if (captured_i) begin
            hold <= 1'b0;
        end else if (capture_i) begin
            hold <= 1'b1;
        end
    end

    assign capture_hold_o = hold;

    // The cycle of a run->training transition is itself the first warm-up cycle.
    assign enable_fall = enable_q & ~enable_i;
    assign warm_done   = (warm_cnt == WARM_DONE) && !enable_fall;

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            enable_q <= 1'b0;
            warm_cnt <= '0;
        end else begin
            enable_q <= enable_i;
            if (enable_fall) begin
                warm_cnt <= WARM_W'(1);
            end else if (warm_cnt != WARM_DONE) begin
                warm_cnt <= warm_cnt + WARM_W'(1);
            end
        end
    end

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        logic [SERDES_WIDTH-1:0]              beat;
        logic [WORD_W-SERDES_WIDTH-1:0]       hist;
        logic [WORD_W-1:0]                    word_now;
        logic [WORD_W-1:0]                    word;
        logic [PAT_W-1:0]                     pat;
        logic [PAT_W+SERDES_WIDTH-1:0]        pat_now;
        logic                                 biterr;
        lock_state_t                          state;
        lock_state_t                          state_next;
        logic [LOCK_W-1:0]                    good_cnt;
        logic [LOCK_W-1:0]                    good_next;

        assign beat     = cout_i[c*SERDES_WIDTH +: SERDES_WIDTH];
        assign word_now = {beat, hist};
        assign pat_now  = {beat, pat};

        always_ff @(posedge sysclk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                hist   <= '0;
                pat    <= '0;
                word   <= '0;
                biterr <= 1'b0;
            end else begin
                hist   <= word_now[WORD_W-1:SERDES_WIDTH];
                pat    <= pat_now[PAT_W+SERDES_WIDTH-1:SERDES_WIDTH];
                if (strobe && !hold) begin
                    word <= word_now;
                end
                biterr <= (beat != pat[SERDES_WIDTH-1:0]) && !enable_i && warm_done;
            end
        end

        always_ff @(posedge sysclk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                state    <= UNLOCKED;
                good_cnt <= '0;
            end else begin
                state    <= state_next;
                good_cnt <= good_next;
            end
        end

        always_comb begin
            state_next = state;
            good_next  = good_cnt;
            if (!enable_i) begin
                case (state)
                    UNLOCKED: begin
                        if (warm_done) begin
                            state_next = CHECKING;
                            good_next  = '0;
                        end
                    end
                    CHECKING: begin
                        if (biterr) begin
                            good_next = '0;
                        end else if (good_cnt == LOCK_LAST) begin
                            state_next = LOCKED;
                        end else begin
                            good_next = good_cnt + LOCK_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (biterr) begin
                            state_next = UNLOCKED;
                        end
                    end
                    default: state_next = UNLOCKED;
                endcase
            end
        end

        assign cout_parallel_o[c*WORD_W +: WORD_W] = word;
        assign biterr_o[c]                         = biterr;
        assign locked_o[c]                         = (state == LOCKED);
    end

`ifdef COUT_PARALLELIZER_ERRCNT_EN
    for (genvar c = 0; c < NCHAN; c++) begin : g_errcnt
        logic [ERRCNT_WIDTH-1:0] errcnt;

        always_ff @(posedge sysclk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                errcnt <= '0;
            end else if (errcnt_clr_i) begin
                errcnt <= '0;
            end else if (g_chan[c].biterr && errcnt != '1) begin
                errcnt <= errcnt + ERRCNT_WIDTH'(1);
            end
        end

        assign errcnt_o[c*ERRCNT_WIDTH +: ERRCNT_WIDTH] = errcnt;
    end
`else
    logic unused_errcnt_clr;
    assign unused_errcnt_clr = errcnt_clr_i;
    assign errcnt_o          = '0;
`endif

endmodule

// File: tb/tb_surf_cout_multi_parallelizer.sv
// Randomised self-checking bench for surf_cout_multi_parallelizer against a beat-history reference model.
// Honours COUT_PARALLELIZER_ERRCNT_EN when the design is built with it.
module tb_surf_cout_multi_parallelizer;

    localparam int NCHAN   = 4;
    localparam int SW      = 4;
    localparam int WB      = 8;
    localparam int WORD_W  = SW * WB;
    localparam int SP      = 16;
    localparam int SOFF    = 4;
    localparam int PP      = 8;
    localparam int LC      = 64;
    localparam int EW      = 4;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic                    sysclk_i     = 1'b0;
    logic                    rst_n_i      = 1'b0;
    logic                    sync_i       = 1'b0;
    logic                    capture_i    = 1'b0;
    logic                    captured_i   = 1'b0;
    logic                    enable_i     = 1'b1;
    logic                    errcnt_clr_i = 1'b0;
    logic [NCHAN*SW-1:0]     cout_i       = '0;
    logic [NCHAN*WORD_W-1:0] cout_parallel_o;
    logic                    capture_hold_o;
    logic [NCHAN-1:0]        biterr_o;
    logic [NCHAN-1:0]        locked_o;
    logic                    sync_err_o;
    logic [NCHAN*EW-1:0]     errcnt_o;

    int checks = 0;
    int errors = 0;

    // stimulus state
    int                  k         = 0;
    int                  sync_mod  = 15;
    bit                  sync_run  = 1'b1;
    int                  data_mode = 0;
    int                  pat_tbl[NCHAN][PP];
    logic [NCHAN*SW-1:0] flip_mask = '0;
    logic [WORD_W-1:0]   saved_word;

    // reference model state
    int                beat_q[NCHAN][$];
    logic [WORD_W-1:0] exp_word[NCHAN];
    logic [NCHAN-1:0]  exp_biterr;
    int                exp_cnt[NCHAN];
    bit                hold_m, seen_m, syncerr_m, en_prev;
    int                phase_m, warm_age;

    surf_cout_multi_parallelizer #(
        .NCHAN(NCHAN), .SERDES_WIDTH(SW), .WORD_BEATS(WB), .SYNC_PERIOD(SP),
        .SYNC_OFFSET(SOFF), .PATTERN_PERIOD(PP), .LOCK_CYCLES(LC), .ERRCNT_WIDTH(EW)
    ) dut (
        .sysclk_i(sysclk_i), .rst_n_i(rst_n_i), .sync_i(sync_i), .capture_i(capture_i),
        .captured_i(captured_i), .enable_i(enable_i), .errcnt_clr_i(errcnt_clr_i),
        .cout_i(cout_i), .cout_parallel_o(cout_parallel_o), .capture_hold_o(capture_hold_o),
        .biterr_o(biterr_o), .locked_o(locked_o), .sync_err_o(sync_err_o), .errcnt_o(errcnt_o)
    );

    always #5 sysclk_i = ~sysclk_i;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int past_beat(input int c, input int d);
        if (d - 1 < beat_q[c].size()) return beat_q[c][d-1];
        return 0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCHAN; c++) begin
            beat_q[c].delete();
            exp_word[c] = '0;
            exp_cnt[c]  = 0;
        end
        exp_biterr = '0;
        hold_m     = 1'b0;
        seen_m     = 1'b0;
        syncerr_m  = 1'b0;
        en_prev    = 1'b0;
        phase_m    = 0;
        warm_age   = 0;
    endtask

    // One clock edge of the reference model, using the inputs sampled at that edge.
    task automatic model_update();
        int cur[NCHAN];
        bit strobe, warm;
        for (int c = 0; c < NCHAN; c++) cur[c] = int'(cout_i[c*SW +: SW]);
        strobe = seen_m && (((phase_m - SOFF + SP) % WB) == 0);
        if (sync_i && seen_m && phase_m != SP - 1) syncerr_m = 1'b1;
        if (strobe && !hold_m) begin
            for (int c = 0; c < NCHAN; c++) begin
                exp_word[c][WORD_W-SW +: SW] = SW'(cur[c]);
                for (int d = 1; d < WB; d++) exp_word[c][(WB-1-d)*SW +: SW] = SW'(past_beat(c, d));
            end
        end
`ifdef COUT_PARALLELIZER_ERRCNT_EN
        for (int c = 0; c < NCHAN; c++) begin
            if (errcnt_clr_i) exp_cnt[c] = 0;
            else if (exp_biterr[c] && exp_cnt[c] < ERR_MAX) exp_cnt[c]++;
        end
`endif
        if (captured_i) hold_m = 1'b0;
        else if (capture_i) hold_m = 1'b1;
        if (en_prev && !enable_i) warm_age = 0;
        warm = warm_age < PP;
        for (int c = 0; c < NCHAN; c++)
            exp_biterr[c] = !enable_i && !warm && (cur[c] != past_beat(c, PP));
        if (warm_age < PP) warm_age++;
        en_prev = enable_i;
        for (int c = 0; c < NCHAN; c++) begin
            beat_q[c].push_front(cur[c]);
            if (beat_q[c].size() > 16) void'(beat_q[c].pop_back());
        end
        if (sync_i) begin
            phase_m = 0;
            seen_m  = 1'b1;
        end else begin
            phase_m = (phase_m + 1) % SP;
        end
    endtask

    task automatic check_all();
        logic [NCHAN*WORD_W-1:0] w;
        logic [NCHAN*EW-1:0]     e;
        for (int c = 0; c < NCHAN; c++) begin
            w[c*WORD_W +: WORD_W] = exp_word[c];
            e[c*EW +: EW]         = EW'(exp_cnt[c]);
        end
        check_output("word", 128'(cout_parallel_o), 128'(w));
        check_output("hold", 128'(capture_hold_o), 128'(hold_m));
        check_output("biterr", 128'(biterr_o), 128'(exp_biterr));
        check_output("sync_err", 128'(sync_err_o), 128'(syncerr_m));
        check_output("errcnt", 128'(errcnt_o), 128'(e));
    endtask

    task automatic apply_stimulus();
        sync_i = sync_run && ((k % SP) == sync_mod);
        for (int c = 0; c < NCHAN; c++) begin
            case (data_mode)
                0:       cout_i[c*SW +: SW] = SW'((k + 3 * c) % 16);
                1:       cout_i[c*SW +: SW] = SW'($urandom_range(0, 15));
                default: cout_i[c*SW +: SW] = SW'(pat_tbl[c][k % PP]);
            endcase
        end
        cout_i = cout_i ^ flip_mask;
    endtask

    task automatic tick();
        @(posedge sysclk_i);
        model_update();
        k++;
        #1;
        check_all();
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            apply_stimulus();
            tick();
        end
    endtask

    initial begin
        for (int c = 0; c < NCHAN; c++)
            for (int i = 0; i < PP; i++) pat_tbl[c][i] = int'($urandom_range(0, 15));
        model_reset();
        repeat (3) @(posedge sysclk_i);
        @(negedge sysclk_i);
        check_all();
        check_output("reset_locked", 128'(locked_o), 128'(0));
        rst_n_i = 1'b1;

        // counting data, syncs at k%16==15
        run_cycles(21);
        check_output("word_ch0_first", 128'(cout_parallel_o[WORD_W-1:0]), 128'(32'h43210FED));
        run_cycles(8);
        check_output("word_ch0_second", 128'(cout_parallel_o[WORD_W-1:0]), 128'(32'hCBA98765));

        // freeze, then release with capture and captured together
        capture_i = 1'b1;
        run_cycles(1);
        capture_i  = 1'b0;
        saved_word = cout_parallel_o[WORD_W-1:0];
        data_mode  = 1;
        run_cycles(40);
        check_output("frozen_hold", 128'(capture_hold_o), 128'(1));
        check_output("frozen_word", 128'(cout_parallel_o[WORD_W-1:0]), 128'(saved_word));
        capture_i  = 1'b1;
        captured_i = 1'b1;
        run_cycles(1);
        capture_i  = 1'b0;
        captured_i = 1'b0;
        check_output("release_hold", 128'(capture_hold_o), 128'(0));
        run_cycles(8);

        // off-phase sync at counter 9
        sync_mod = 9;
        run_cycles(9);
        check_output("sync_err_before", 128'(sync_err_o), 128'(0));
        run_cycles(2);
        check_output("sync_err_set", 128'(sync_err_o), 128'(1));
        run_cycles(30);
        check_output("sync_err_sticky", 128'(sync_err_o), 128'(1));

        // training with a period-8 pattern
        data_mode = 2;
        enable_i  = 1'b0;
        run_cycles(LC - 3);
        check_output("locked_early", 128'(locked_o), 128'(0));
        run_cycles(20);
        check_output("locked_all", 128'(locked_o), 128'(4'b1111));

        // single-beat bit flip on channel 2
        flip_mask = (NCHAN*SW)'(1) << (2 * SW);
        run_cycles(1);
        flip_mask = '0;
        check_output("flip_biterr", 128'(biterr_o), 128'(4'b0100));
        run_cycles(1);
        check_output("flip_biterr_clear", 128'(biterr_o), 128'(0));
        check_output("flip_unlock", 128'(locked_o), 128'(4'b1011));
        run_cycles(10);
        check_output("flip_still_unlocked", 128'(locked_o), 128'(4'b1011));

        // random data in training mode drives error counters
        data_mode = 1;
        run_cycles(30);
`ifdef COUT_PARALLELIZER_ERRCNT_EN
        check_output("errcnt_saturated", 128'(errcnt_o), 128'(16'hFFFF));
`else
        check_output("errcnt_tied", 128'(errcnt_o), 128'(0));
`endif
        errcnt_clr_i = 1'b1;
        run_cycles(1);
        errcnt_clr_i = 1'b0;
        check_output("errcnt_clear", 128'(errcnt_o), 128'(0));
        run_cycles(5);

        // asynchronous reset while frozen
        enable_i  = 1'b1;
        data_mode = 0;
        capture_i = 1'b1;
        run_cycles(1);
        capture_i = 1'b0;
        run_cycles(3);
        check_output("pre_reset_hold", 128'(capture_hold_o), 128'(1));
        #2;
        rst_n_i = 1'b0;
        #1;
        check_output("async_word", 128'(cout_parallel_o), 128'(0));
        check_output("async_hold", 128'(capture_hold_o), 128'(0));
        check_output("async_biterr", 128'(biterr_o), 128'(0));
        check_output("async_locked", 128'(locked_o), 128'(0));
        check_output("async_sync_err", 128'(sync_err_o), 128'(0));
        check_output("async_errcnt", 128'(errcnt_o), 128'(0));
        model_reset();
        @(negedge sysclk_i);
        rst_n_i  = 1'b1;
        sync_run = 1'b0;
        run_cycles(20);
        check_output("no_strobe_before_sync", 128'(cout_parallel_o), 128'(0));
        sync_run = 1'b1;
        sync_mod = k % SP;
        run_cycles(25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/surf_cout_multi_parallelizer.md
Name: surf_cout_multi_parallelizer

Overview:
- Parametrised multi-channel successor to the single-channel SURF COUT parallelizer in the TURFIO SURF datapath.
- Deserialises NCHAN ISERDES nibble streams into WORD_BEATS-beat words, phase-aligned to the global sync period.
- Freezes all words on a register-core capture handshake.
- Adds training-mode bit-error checking with warm-up masking, a per-channel lock FSM, sync-phase error detection and optional error counters.

Parameters:
- NCHAN, 4, number of COUT channels.
- SERDES_WIDTH, 4, bits per channel per sysclk beat.
- WORD_BEATS, 8, beats per parallel word; WORD_W = SERDES_WIDTH*WORD_BEATS.
- SYNC_PERIOD, 16, sysclk cycles between sync_i pulses; must be a multiple of WORD_BEATS.
- SYNC_OFFSET, 4, phase (0..WORD_BEATS-1) of the first capture strobe after sync.
- PATTERN_PERIOD, 8, training-pattern repeat length in beats (1..16).
- LOCK_CYCLES, 64, consecutive error-free beats required to lock.
- ERRCNT_WIDTH, 16, per-channel error counter width.

Ports:
- sysclk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- sync_i  in  1  one-cycle pulse every SYNC_PERIOD clocks
- capture_i  in  1  freeze request from register core
- captured_i  in  1  release from register core
- enable_i  in  1  1 = run mode (checking off), 0 = training mode
- errcnt_clr_i  in  1  clear all error counters
- cout_i  in  NCHAN*SERDES_WIDTH  ISERDES data, channel c at [c*SERDES_WIDTH +: SERDES_WIDTH]
- cout_parallel_o  out  NCHAN*WORD_W  captured words, channel c at [c*WORD_W +: WORD_W]
- capture_hold_o  out  1  words frozen
- biterr_o  out  NCHAN  per-channel bit error, registered
- locked_o  out  NCHAN  per-channel lock status
- sync_err_o  out  1  sticky: sync_i seen off-phase
- errcnt_o  out  NCHAN*ERRCNT_WIDTH  per-channel saturating error counts

Behaviour:
- Reset (async assert, sync release): all outputs 0, history 0, phase counter 0, sync_seen 0, lock FSMs UNLOCKED, warm-up counter 0.
- Phase counter: loads 0 in the cycle sync_i=1, else increments mod SYNC_PERIOD. sync_seen is set on the first sync_i.
- sync_err_o: set if sync_i=1 while sync_seen=1 and counter != SYNC_PERIOD-1. The counter still realigns. Cleared only by reset.
- Capture strobe: asserted when sync_seen=1 and (counter - SYNC_OFFSET) mod WORD_BEATS == 0. No strobes before the first sync.
- On a strobe with hold=0, each channel word = {cout_i[c], last WORD_BEATS-1 beats}: newest beat in the MSBs, oldest in the LSBs. Output is visible the next cycle.
- Hold handshake: capture_i sets hold and captured_i clears it, both effective the next cycle. captured_i wins if both are asserted together. While hold=1, words are unchanged regardless of strobes.
- Bit error (per channel): compares the current beat against the beat PATTERN_PERIOD cycles earlier; biterr_o = mismatch, one-cycle latency.
- biterr_o is forced 0 when enable_i=1, and during warm-up.
- Warm-up: the first PATTERN_PERIOD cycles after reset or after any enable_i 1->0 transition. The warm-up counter restarts on each such transition.
- Lock FSM (per channel), driven by the registered biterr:
  - UNLOCKED: moves to CHECKING when enable_i=0 and warm-up is done.
  - CHECKING: error-free beats counted; any error resets the count to 0; count == LOCK_CYCLES-1 with no error moves to LOCKED.
  - LOCKED: an error moves to UNLOCKED.
  - enable_i=1 freezes the state.
  - locked_o = (state == LOCKED), registered.
- Channels are fully independent except for the shared phase counter and hold.

Optional Feature:
- Macro: COUT_PARALLELIZER_ERRCNT_EN.
- Defined: each channel increments errcnt on every registered biterr, saturating at all-ones. errcnt_clr_i zeroes all counters next cycle and wins over a simultaneous increment.
- Undefined: no counter logic; errcnt_o is tied to 0 and errcnt_clr_i is ignored.

Test Plan:
- Reset, then sync_i every 16 clocks with cout_i[ch0] = beat index 0..15: after the strobe at counter=4, ch0 word = 0x43210FED. The next word, at counter=12, = 0xCBA98765.
- capture_i pulse, then 40 clocks of changing data: cout_parallel_o is unchanged and capture_hold_o=1. Assert captured_i and capture_i together: hold clears and the next strobe updates the word.
- Off-phase sync: sync_i at counter=9 sets sync_err_o=1, and strobes follow the new phase. The flag persists until rst_n_i=0.
- enable_i=0 with a period-8 pattern: biterr_o stays 0 through warm-up, and locked_o rises LOCK_CYCLES beats after warm-up ends.
- Then flip one bit on ch2: biterr_o[2] pulses for 1 cycle and locked_o[2] drops; other channels stay locked.
- With COUT_PARALLELIZER_ERRCNT_EN and ERRCNT_WIDTH=4: 20 error beats give errcnt=0xF (saturated). errcnt_clr_i coinciding with an error gives 0.
- Assert rst_n_i mid-capture with hold=1: all outputs are 0 immediately (asynchronous), and there are no strobes after release until the next sync_i.
